// File: rtl/mul_pkg.sv
// ============================================================================
//  Module   : mul_pkg
//  Brief    : Shared state encoding and handshake constants for mul_seq_param.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } mul_state_t;

    localparam logic MulStart          = 1'b1;
    localparam logic MulStop           = 1'b0;
    localparam logic MulResultReady    = 1'b1;
    localparam logic MulResultNotReady = 1'b0;

    // Replicated by users to build a zero word of any WIDTH.
    localparam logic MulZeroBit        = 1'b0;

endpackage

`default_nettype wire

// File: rtl/mul_pp_gen.sv
// ============================================================================
//  Module   : mul_pp_gen
//  Brief    : Partial product of a 2*WIDTH multiplicand and a BPC-bit digit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_pp_gen #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic [2*WIDTH-1:0] i_mcand,
    input  logic [BPC-1:0]     i_digit,
    output logic [2*WIDTH-1:0] o_pp
);

    logic [2*WIDTH-1:0] w_terms [BPC];

    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_term
            assign w_terms[gi] = i_digit[gi] ? (i_mcand << gi) : '0;
        end
    endgenerate

    always_comb begin
        o_pp = '0;
        for (int i = 0; i < BPC; i++) begin
            o_pp = o_pp + w_terms[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/mul_seq_param.sv
// ============================================================================
//  Module   : mul_seq_param
//  Brief    : Iterative shift-add multiplier retiring BPC multiplier bits/cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_seq_param
    import mul_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BPC       = 1,
    parameter int EARLY_OUT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_mul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int                 c_iters   = WIDTH / BPC;
    localparam int                 CNT_W     = $clog2(c_iters + 1);
    localparam logic [CNT_W-1:0]   c_last    = CNT_W'(c_iters - 1);
    localparam logic [CNT_W-1:0]   c_cnt_one = CNT_W'(1);
    localparam logic [WIDTH-1:0]   c_zero_w  = {WIDTH{MulZeroBit}};
    localparam logic [WIDTH-1:0]   c_one_w   = {{(WIDTH-1){MulZeroBit}}, 1'b1};
    localparam logic [2*WIDTH-1:0] c_zero_dw = {(2*WIDTH){MulZeroBit}};
    localparam logic [2*WIDTH-1:0] c_one_dw  = {{(2*WIDTH-1){MulZeroBit}}, 1'b1};

    mul_state_t         r_state;
    mul_state_t         w_next;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_product;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic               w_accept;
    logic               w_zero_op;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH-1:0]   w_mplier_next;
    logic [2*WIDTH-1:0] w_pp;
    logic               w_run_last;
    logic               w_release;

    assign w_accept  = (r_state == ST_IDLE) && (start_i == MulStart) && !annul_i;
    assign w_zero_op = (opdata1_i == c_zero_w) || (opdata2_i == c_zero_w);

    // Magnitudes fit in WIDTH unsigned bits, including the signed minimum.
    assign w_mag1 = (signed_mul_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + c_one_w) : opdata1_i;
    assign w_mag2 = (signed_mul_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + c_one_w) : opdata2_i;

    assign w_mplier_next = r_mplier >> BPC;
    assign w_run_last    = (r_cnt == c_last) ||
                           ((EARLY_OUT != 0) && (w_mplier_next == c_zero_w));
    assign w_release     = (start_i == MulStop) || annul_i;

    mul_pp_gen #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_pp_gen (
        .i_mcand (r_mcand),
        .i_digit (r_mplier[BPC-1:0]),
        .o_pp    (w_pp)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_zero_op ? ST_SIGN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (annul_i) begin
                    w_next = ST_IDLE;
                end else if (w_run_last) begin
                    w_next = ST_SIGN;
                end
            end
            ST_SIGN: begin
                w_next = annul_i ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (w_release) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand   <= c_zero_dw;
            r_mplier  <= c_zero_w;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_product <= c_zero_dw;
            r_result  <= c_zero_dw;
            r_ready   <= MulResultNotReady;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mcand   <= {c_zero_w, w_mag1};
                        r_mplier  <= w_mag2;
                        r_neg     <= signed_mul_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        r_product <= c_zero_dw;
                        r_cnt     <= '0;
                    end
                end
                ST_RUN: begin
                    if (!annul_i) begin
                        r_product <= r_product + w_pp;
                        r_mcand   <= r_mcand << BPC;
                        r_mplier  <= w_mplier_next;
                        r_cnt     <= r_cnt + c_cnt_one;
                    end
                end
                ST_SIGN: begin
                    if (!annul_i) begin
                        r_result <= r_neg ? (~r_product + c_one_dw) : r_product;
                        r_ready  <= MulResultReady;
                    end
                end
                ST_DONE: begin
                    if (w_release) begin
                        r_result <= c_zero_dw;
                        r_ready  <= MulResultNotReady;
                    end
                end
                default: begin
                    r_result <= c_zero_dw;
                    r_ready  <= MulResultNotReady;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = (r_state == ST_RUN) || (r_state == ST_SIGN);

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_param.sv
// ============================================================================
//  Module   : tb_mul_seq_param
//  Brief    : Directed bench for mul_seq_param at BPC 1/2/4 (WIDTH=32).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_seq_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        sgn;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        annul;
    logic        start [3];
    logic [63:0] res   [3];
    logic        rdy   [3];
    logic        bsy   [3];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Index 0: BPC=1 early-out, 1: BPC=2 full run, 2: BPC=4 full run.
    mul_seq_param #(.WIDTH(32), .BPC(1), .EARLY_OUT(1)) u_dut_b1 (
        .clk(clk), .rst(rst), .signed_mul_i(sgn), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start[0]), .annul_i(annul), .result_o(res[0]), .ready_o(rdy[0]), .busy_o(bsy[0]));

    mul_seq_param #(.WIDTH(32), .BPC(2), .EARLY_OUT(0)) u_dut_b2 (
        .clk(clk), .rst(rst), .signed_mul_i(sgn), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start[1]), .annul_i(annul), .result_o(res[1]), .ready_o(rdy[1]), .busy_o(bsy[1]));

    mul_seq_param #(.WIDTH(32), .BPC(4), .EARLY_OUT(0)) u_dut_b4 (
        .clk(clk), .rst(rst), .signed_mul_i(sgn), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start[2]), .annul_i(annul), .result_o(res[2]), .ready_o(rdy[2]), .busy_o(bsy[2]));

    typedef struct {
        int          sel;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic        junk;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input int sel, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic junk,
                          input logic [63:0] exp, input int lat);
        int edges;
        logic got;
        @(negedge clk);
        sgn        = s;
        op1        = a;
        op2        = b;
        start[sel] = 1'b1;
        @(posedge clk);
        if (junk) begin
            #1;
            op1 = 32'hA5A5_5A5A;
            op2 = 32'h3C3C_C3C3;
            sgn = ~s;
        end
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (rdy[sel]) begin
                got = 1'b1;
            end else if (edges == 1) begin
                check("busy_during_op", 64'(bsy[sel]), 64'd1);
                check("result_zero_while_busy", res[sel], 64'd0);
            end
        end
        check("latency", 64'(edges), 64'(lat));
        check("result", res[sel], exp);
        @(negedge clk);
        start[sel] = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_drop", 64'(rdy[sel]), 64'd0);
        check("result_after_drop", res[sel], 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;

        vecs[0]  = '{0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 33};
        vecs[1]  = '{0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 33};
        vecs[2]  = '{0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 4};
        vecs[3]  = '{1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'h0B00_EA4E_242D_2080, 17};
        vecs[4]  = '{2, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'h0B00_EA4E_242D_2080, 9};
        vecs[5]  = '{0, 1'b0, 32'h1234_5678, 32'h0000_0001, 1'b0, 64'h0000_0000_1234_5678, 2};
        vecs[6]  = '{0, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 64'h0000_0000_0000_0000, 1};
        vecs[7]  = '{0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_0000_0001, 2};
        vecs[8]  = '{2, 1'b1, 32'h0000_0005, 32'hFFFF_FFFA, 1'b0, 64'hFFFF_FFFF_FFFF_FFE2, 9};
        vecs[9]  = '{1, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 64'hC000_0000_8000_0000, 17};
        vecs[10] = '{0, 1'b0, 32'h0000_0003, 32'h0001_0000, 1'b0, 64'h0000_0000_0003_0000, 18};

        rst   = 1'b0;
        sgn   = 1'b0;
        op1   = '0;
        op2   = '0;
        annul = 1'b0;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_ready", 64'(rdy[i]), 64'd0);
            check("reset_result", res[i], 64'd0);
            check("reset_busy", 64'(bsy[i]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 11; v++) begin
            run_op(vecs[v].sel, vecs[v].sgn, vecs[v].a, vecs[v].b,
                   vecs[v].junk, vecs[v].exp, vecs[v].lat);
        end

        // Annul after ten RUN edges: no result may ever appear.
        @(negedge clk);
        sgn      = 1'b0;
        op1      = 32'hFFFF_FFFF;
        op2      = 32'hFFFF_FFFF;
        start[0] = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul    = 1'b1;
        start[0] = 1'b0;
        @(posedge clk);
        #1;
        check("annul_busy", 64'(bsy[0]), 64'd0);
        check("annul_ready", 64'(rdy[0]), 64'd0);
        @(negedge clk);
        annul = 1'b0;
        seen  = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (rdy[0]) seen++;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        run_op(0, 1'b0, 32'd5, 32'd6, 1'b0, 64'd30, 4);

        // Asynchronous reset between edges in the middle of RUN.
        @(negedge clk);
        sgn      = 1'b0;
        op1      = 32'hFFFF_FFFF;
        op2      = 32'hFFFF_FFFF;
        start[0] = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_busy", 64'(bsy[0]), 64'd1);
        #2;
        rst      = 1'b0;
        start[0] = 1'b0;
        #1;
        check("async_reset_busy", 64'(bsy[0]), 64'd0);
        check("async_reset_ready", 64'(rdy[0]), 64'd0);
        check("async_reset_result", res[0], 64'd0);
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (rdy[0] || bsy[0]) seen++;
        end
        check("post_reset_idle", 64'(seen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
